// File: rtl/dm_store_merge_if.sv
// Store request channel from the MEM stage plus the word-wide DM port.
// The slave modport is the store-merge block; master is the requester/memory side.
interface dm_store_merge_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_addr, req_wdata, req_op, mem_rdata,
        input  req_ready, mem_addr, mem_rd, mem_we, mem_wdata, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_op, mem_rdata,
        output req_ready, mem_addr, mem_rd, mem_we, mem_wdata, done, err
    );
endinterface

// File: rtl/dm_store_merge.sv
// Performs sw/sh/sb against a DM without byte enables: full words are written
// directly, sub-word stores do read-merge-write, misaligned/illegal ops are rejected.
module dm_store_merge #(
    parameter int ADDR_W = 32
) (
    input logic            clk,
    input logic            reset,
    dm_store_merge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        op_q;
    logic [31:0]       merged_q;
    logic              err_q;
    logic              accept;
    logic              legal;
    logic [31:0]       merge_word;
    logic [ADDR_W-1:0] word_addr;

    assign accept    = bus.req_valid && (state == IDLE);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        legal = 1'b0;
        case (bus.req_op)
            2'b00:   legal = (bus.req_addr[1:0] == 2'b00);
            2'b01:   legal = ~bus.req_addr[0];
            2'b10:   legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!legal)                  next_state = RESP;
                    else if (bus.req_op == 2'b00) next_state = WR;
                    else                         next_state = RD;
                end
            end
            RD:      next_state = MRG;
            MRG:     next_state = WR;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Only SH and SB ever reach MRG, so anything that is not SH is a byte lane.
    always_comb begin
        merge_word = bus.mem_rdata;
        if (op_q == 2'b01) begin
            if (addr_q[1]) merge_word[31:16] = wdata_q;
            else           merge_word[15:0]  = wdata_q;
        end else begin
            case (addr_q[1:0])
                2'b00:   merge_word[7:0]   = wdata_q[7:0];
                2'b01:   merge_word[15:8]  = wdata_q[7:0];
                2'b10:   merge_word[23:16] = wdata_q[7:0];
                default: merge_word[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // A full-word store takes its write data straight from the request;
    // sub-word stores overwrite it with the merged word in MRG.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            op_q     <= '0;
            merged_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata[15:0];
            op_q     <= bus.req_op;
            merged_q <= bus.req_wdata;
            err_q    <= ~legal;
        end else if (state == MRG) begin
            merged_q <= merge_word;
        end
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            RD: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = word_addr;
            end
            WR: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = word_addr;
                bus.mem_wdata = merged_q;
            end
            RESP: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dm_store_merge.sv
// Self-checking bench for dm_store_merge: directed cases plus random stores
// checked against a byte-addressed reference memory.
module tb_dm_store_merge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_store_merge_if #(.ADDR_W(32)) bus ();
    dm_store_merge #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] dm [0:255];
    logic [7:0]  ref_bytes [0:1023];

    // Word-wide DM: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= dm[bus.mem_addr[9:2]];
        if (bus.mem_we) dm[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    int          o_rd_cnt, o_we_cnt, o_done_cnt, o_rd_cyc, o_we_cyc, o_done_cyc, o_ready_cyc, o_bad;
    logic        o_err;
    logic [31:0] o_rd_addr, o_we_addr, o_wdata;

    task automatic clear_obs();
        o_rd_cnt = 0; o_we_cnt = 0; o_done_cnt = 0; o_rd_cyc = 0; o_we_cyc = 0;
        o_done_cyc = 0; o_ready_cyc = 0; o_bad = 0; o_err = 1'b0;
        o_rd_addr = '0; o_we_addr = '0; o_wdata = '0;
    endtask

    task automatic sample(input int k);
        if (bus.mem_rd) begin
            o_rd_cnt++;
            if (o_rd_cyc == 0) begin o_rd_cyc = k; o_rd_addr = bus.mem_addr; end
        end
        if (bus.mem_we) begin
            o_we_cnt++;
            if (o_we_cyc == 0) begin o_we_cyc = k; o_we_addr = bus.mem_addr; o_wdata = bus.mem_wdata; end
        end
        if (bus.done) begin
            o_done_cnt++;
            if (o_done_cyc == 0) begin o_done_cyc = k; o_err = bus.err; end
        end
        if (bus.err && !bus.done) o_bad++;
        if (!bus.mem_rd && !bus.mem_we && (bus.mem_addr != 0 || bus.mem_wdata != 0)) o_bad++;
        if (bus.req_ready && o_ready_cyc == 0) o_ready_cyc = k;
    endtask

    // Issue one request from IDLE and observe the eight cycles after acceptance.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_wdata = data; bus.req_op = op;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_op = 2'($urandom);
        clear_obs();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sample(k);
        end
    endtask

    function automatic void ref_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op,
                                      output logic legal, output logic [31:0] word);
        int a, nbytes, base;
        a = int'(addr[9:0]);
        legal = (op == 2'd0 && a % 4 == 0) || (op == 2'd1 && a % 2 == 0) || (op == 2'd2);
        nbytes = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
        if (legal)
            for (int i = 0; i < nbytes; i++) ref_bytes[a + i] = data[8*i +: 8];
        base = a - (a % 4);
        word = {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        logic l;
        logic [31:0] w;
        ref_store(addr, val, 2'd0, l, w);
        run_txn(addr, val, 2'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.req_ready); end
        n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd got=%b exp=0", bus.mem_rd); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we got=%b exp=0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr got=%h exp=0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wdata got=%h exp=0", bus.mem_wdata); end
        n_cmp++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done_err got=%b%b exp=00", bus.done, bus.err); end
        reset = 1'b0;
    endtask

    task automatic test_sw();
        logic l;
        logic [31:0] w;
        ref_store(32'h10, 32'hDEADBEEF, 2'd0, l, w);
        run_txn(32'h10, 32'hDEADBEEF, 2'd0);
        n_cmp++; if (o_we_cyc !== 1 || o_we_cnt !== 1) begin n_fail++; $display("[TB] FAIL sw_we_timing got=%0d/%0d exp=1/1", o_we_cyc, o_we_cnt); end
        n_cmp++; if (o_we_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL sw_addr got=%h exp=10", o_we_addr); end
        n_cmp++; if (o_wdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL sw_wdata got=%h exp=deadbeef", o_wdata); end
        n_cmp++; if (o_done_cyc !== 2 || o_done_cnt !== 1 || o_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_done got=%0d/%0d err=%b exp=2/1 err=0", o_done_cyc, o_done_cnt, o_err); end
        n_cmp++; if (o_rd_cnt !== 0) begin n_fail++; $display("[TB] FAIL sw_no_rd got=%0d exp=0", o_rd_cnt); end
        n_cmp++; if (o_ready_cyc !== 3) begin n_fail++; $display("[TB] FAIL sw_ready got=%0d exp=3", o_ready_cyc); end
    endtask

    task automatic test_sb_sh();
        logic l;
        logic [31:0] w;
        preload(32'h20, 32'h11223344);
        ref_store(32'h21, 32'h000000AB, 2'd2, l, w);
        run_txn(32'h21, 32'h000000AB, 2'd2);
        n_cmp++; if (o_rd_cyc !== 1 || o_rd_addr !== 32'h20) begin n_fail++; $display("[TB] FAIL sb_rd got=%0d@%h exp=1@20", o_rd_cyc, o_rd_addr); end
        n_cmp++; if (o_we_cyc !== 3 || o_we_addr !== 32'h20) begin n_fail++; $display("[TB] FAIL sb_we got=%0d@%h exp=3@20", o_we_cyc, o_we_addr); end
        n_cmp++; if (o_wdata !== 32'h1122AB44) begin n_fail++; $display("[TB] FAIL sb_wdata got=%h exp=1122ab44", o_wdata); end
        n_cmp++; if (o_done_cyc !== 4 || o_ready_cyc !== 5) begin n_fail++; $display("[TB] FAIL sb_done_ready got=%0d/%0d exp=4/5", o_done_cyc, o_ready_cyc); end
        preload(32'h30, 32'h11223344);
        run_txn(32'h32, 32'h0000CAFE, 2'd1);
        ref_store(32'h32, 32'h0000CAFE, 2'd1, l, w);
        n_cmp++; if (o_wdata !== 32'hCAFE3344) begin n_fail++; $display("[TB] FAIL sh_hi_wdata got=%h exp=cafe3344", o_wdata); end
        preload(32'h30, 32'h11223344);
        run_txn(32'h30, 32'h0000CAFE, 2'd1);
        ref_store(32'h30, 32'h0000CAFE, 2'd1, l, w);
        n_cmp++; if (o_wdata !== 32'h1122CAFE) begin n_fail++; $display("[TB] FAIL sh_lo_wdata got=%h exp=1122cafe", o_wdata); end
        n_cmp++; if (o_we_cnt !== 1 || o_done_cnt !== 1) begin n_fail++; $display("[TB] FAIL sh_pulses got=%0d/%0d exp=1/1", o_we_cnt, o_done_cnt); end
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [3] = '{32'h06, 32'h05, 32'h08};
        logic [1:0]  ops   [3] = '{2'd0, 2'd1, 2'd3};
        for (int i = 0; i < 3; i++) begin
            run_txn(addrs[i], $urandom, ops[i]);
            n_cmp++; if (o_done_cyc !== 1 || o_err !== 1'b1 || o_done_cnt !== 1) begin n_fail++; $display("[TB] FAIL illegal%0d_done got=%0d err=%b n=%0d exp=1 err=1 n=1", i, o_done_cyc, o_err, o_done_cnt); end
            n_cmp++; if (o_rd_cnt !== 0 || o_we_cnt !== 0) begin n_fail++; $display("[TB] FAIL illegal%0d_mem got=rd%0d we%0d exp=0/0", i, o_rd_cnt, o_we_cnt); end
            n_cmp++; if (o_ready_cyc !== 2 || o_bad !== 0) begin n_fail++; $display("[TB] FAIL illegal%0d_ready got=%0d bad=%0d exp=2 bad=0", i, o_ready_cyc, o_bad); end
        end
    endtask

    task automatic test_sb_lanes();
        logic l;
        logic [31:0] w;
        preload(32'h40, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) begin
            ref_store(32'h40 + 32'(i), 32'(i + 1), 2'd2, l, w);
            run_txn(32'h40 + 32'(i), 32'(i + 1), 2'd2);
            n_cmp++; if (o_wdata !== w) begin n_fail++; $display("[TB] FAIL lane%0d_wdata got=%h exp=%h", i, o_wdata, w); end
        end
        n_cmp++; if (dm[16] !== 32'h04030201) begin n_fail++; $display("[TB] FAIL lanes_final got=%h exp=04030201", dm[16]); end
    endtask

    task automatic test_reset_mid();
        logic ready3;
        logic l;
        logic [31:0] w;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h51; bus.req_wdata = 32'h5A; bus.req_op = 2'd2;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        clear_obs();
        ready3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 2) reset = 1'b1;
            if (k == 3) begin ready3 = bus.req_ready; reset = 1'b0; end
        end
        n_cmp++; if (ready3 !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready got=%b exp=1", ready3); end
        n_cmp++; if (o_we_cnt !== 0 || o_done_cnt !== 0) begin n_fail++; $display("[TB] FAIL rstmid_dropped got=we%0d done%0d exp=0/0", o_we_cnt, o_done_cnt); end
        ref_store(32'h54, 32'h0BADF00D, 2'd0, l, w);
        run_txn(32'h54, 32'h0BADF00D, 2'd0);
        n_cmp++; if (o_wdata !== w || o_we_cyc !== 1 || o_done_cyc !== 2) begin n_fail++; $display("[TB] FAIL rstmid_after got=%h we%0d done%0d exp=%h we1 done2", o_wdata, o_we_cyc, o_done_cyc, w); end
    endtask

    task automatic test_back_to_back();
        int          we_at[$];
        int          done_at[$];
        logic [31:0] wd[$];
        logic        l, prev_ready;
        logic [31:0] e1, e2;
        ref_store(32'h60, 32'hA5A50001, 2'd0, l, e1);
        ref_store(32'h64, 32'h5A5A0002, 2'd0, l, e2);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h60; bus.req_wdata = 32'hA5A50001; bus.req_op = 2'd0;
        @(posedge clk);
        #1;
        bus.req_addr = 32'h64; bus.req_wdata = 32'h5A5A0002;
        prev_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin we_at.push_back(k); wd.push_back(bus.mem_wdata); end
            if (bus.done) done_at.push_back(k);
            if (prev_ready) bus.req_valid = 1'b0;
            prev_ready = bus.req_ready;
        end
        bus.req_valid = 1'b0;
        n_cmp++; if (we_at.size() !== 2 || done_at.size() !== 2) begin n_fail++; $display("[TB] FAIL b2b_counts got=we%0d done%0d exp=2/2", we_at.size(), done_at.size()); end
        n_cmp++; if (we_at.size() != 2 || we_at[0] !== 1 || we_at[1] !== 4) begin n_fail++; $display("[TB] FAIL b2b_we_cycles got=%p exp=1,4", we_at); end
        n_cmp++; if (done_at.size() != 2 || done_at[1] !== 5) begin n_fail++; $display("[TB] FAIL b2b_done2 got=%p exp=2,5", done_at); end
        n_cmp++; if (wd.size() != 2 || wd[0] !== e1 || wd[1] !== e2) begin n_fail++; $display("[TB] FAIL b2b_wdata got=%p exp=%h,%h", wd, e1, e2); end
    endtask

    task automatic test_random();
        logic [31:0] addr, data, w;
        logic [1:0]  op;
        logic        legal;
        int          exp_rd, exp_we, exp_done, exp_ready;
        for (int i = 0; i < 64; i++) preload(32'(4 * i), $urandom);
        for (int i = 0; i < 40; i++) begin
            addr = 32'($urandom_range(0, 255));
            op   = 2'($urandom_range(0, 3));
            data = $urandom;
            ref_store(addr, data, op, legal, w);
            run_txn(addr, data, op);
            if (!legal)          begin exp_rd = 0; exp_we = 0; exp_done = 1; exp_ready = 2; end
            else if (op == 2'd0) begin exp_rd = 0; exp_we = 1; exp_done = 2; exp_ready = 3; end
            else                 begin exp_rd = 1; exp_we = 1; exp_done = 4; exp_ready = 5; end
            n_cmp++; if (o_rd_cnt !== exp_rd || o_we_cnt !== exp_we) begin n_fail++; $display("[TB] FAIL rnd%0d_strobes got=rd%0d we%0d exp=rd%0d we%0d", i, o_rd_cnt, o_we_cnt, exp_rd, exp_we); end
            n_cmp++; if (o_done_cyc !== exp_done || o_done_cnt !== 1 || o_err !== !legal) begin n_fail++; $display("[TB] FAIL rnd%0d_done got=%0d n%0d err=%b exp=%0d n1 err=%b", i, o_done_cyc, o_done_cnt, o_err, exp_done, !legal); end
            n_cmp++; if (o_ready_cyc !== exp_ready || o_bad !== 0) begin n_fail++; $display("[TB] FAIL rnd%0d_ready got=%0d bad=%0d exp=%0d bad=0", i, o_ready_cyc, o_bad, exp_ready); end
            if (legal) begin
                n_cmp++; if (o_wdata !== w || o_we_addr !== (addr & ~32'h3)) begin n_fail++; $display("[TB] FAIL rnd%0d_write got=%h@%h exp=%h@%h", i, o_wdata, o_we_addr, w, addr & ~32'h3); end
            end
            if (exp_rd == 1) begin
                n_cmp++; if (o_rd_addr !== (addr & ~32'h3)) begin n_fail++; $display("[TB] FAIL rnd%0d_rdaddr got=%h exp=%h", i, o_rd_addr, addr & ~32'h3); end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_op    = '0;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;
        test_reset();
        test_sw();
        test_sb_sh();
        test_illegal();
        test_sb_lanes();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_store_merge.md
# dm_store_merge

Store-side companion to the data-memory load-extension logic: accepts sw/sh/sb requests from the MEM stage and performs them against a word-wide data memory that has no byte enables. Full-word stores are written directly; byte/halfword stores perform read-modify-write (read word, merge lane, write back). Misaligned or illegal stores are rejected with an error pulse and no memory access. Sits between the MEM-stage store path and the DM array.

## Interface
Parameters:
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- req_valid  in  1  store request present
- req_ready  out  1  block can accept; high only in IDLE
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (sb uses [7:0], sh uses [15:0])
- req_op  in  2  00 SW, 01 SH, 10 SB, 11 illegal
- mem_addr  out  ADDR_W  word address to DM, low 2 bits always 0
- mem_rd  out  1  read strobe; mem_rdata valid the following cycle
- mem_rdata  in  32  read data
- mem_we  out  1  write strobe, one cycle per accepted legal store
- mem_wdata  out  32  write data
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done for rejected requests

## Operation
- Accept on req_valid && req_ready; latch addr, wdata, op. Inputs ignored until next IDLE.
- Legality: SW needs addr[1:0]==00; SH needs addr[0]==0; SB always legal; op 11 illegal.
- States: IDLE, RD, MRG, WR, RESP.
  - IDLE: req_ready=1. On accept: illegal -> RESP (err flagged); SW -> WR with merged word = wdata; SH/SB -> RD.
  - RD: mem_rd=1, mem_addr={addr[ADDR_W-1:2],2'b00}. -> MRG.
  - MRG: capture merged word from mem_rdata. -> WR.
  - WR: mem_we=1, mem_addr as above, mem_wdata=merged word. -> RESP.
  - RESP: done=1; err=1 if rejected. -> IDLE.
- Merge: SB lane k=addr[1:0] replaces bits [8k+7:8k] with wdata[7:0]; SH addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with wdata[15:0]; other bits kept from mem_rdata.
- Rejected requests never assert mem_rd or mem_we.
- Outside RD/WR: mem_rd=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: req_ready=1 (IDLE), mem_rd=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0; merged/latched registers cleared.
- Accept at cycle T:
  - SW: WR at T+1, done at T+2, req_ready at T+3.
  - SH/SB: mem_rd at T+1, rdata sampled at T+2, mem_we at T+3, done at T+4, req_ready at T+5.
  - Illegal: done+err at T+1, req_ready at T+2.
- Exactly one mem_we per legal request; done/err are single-cycle pulses.
- req_valid while req_ready=0: not accepted, no effect; request must be held by the source.
- Reset mid-operation (any state): next cycle IDLE, pending write dropped, no done.
- Back-to-back: a request valid at RESP+1 (IDLE) is accepted that cycle.

## Test plan
- Reset then SW addr 0x10, data 0xDEADBEEF -> mem_we at T+1, mem_addr 0x10, mem_wdata 0xDEADBEEF, done at T+2, no mem_rd.
- SB addr 0x21, data 0x000000AB, mem_rdata 0x11223344 -> mem_rd at T+1 addr 0x20, mem_we at T+3 mem_wdata 0x1122AB44, done T+4.
- SH addr 0x32, data 0x0000CAFE, mem_rdata 0x11223344 -> mem_wdata 0xCAFE3344; SH addr 0x30 same rdata -> 0x1122CAFE.
- SW addr 0x06, SH addr 0x05, op 11 -> each gives done=err=1 at T+1, no mem_rd/mem_we, req_ready at T+2.
- SB lanes 0..3 at 0x40..0x43 with data 0x01..0x04, memory model returning last write -> final word 0x04030201.
- Assert reset during MRG of an SB -> no mem_we, no done, req_ready=1 next cycle; subsequent SW completes normally.
